// File: rtl/tmds_pkg.sv
// Shared TMDS constants: token width, the four control symbols and the alignment training token.
package tmds_pkg;

    localparam int TMDS_TOKEN_W = 10;

    localparam logic [TMDS_TOKEN_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [TMDS_TOKEN_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [TMDS_TOKEN_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [TMDS_TOKEN_W-1:0] CTRL_11 = 10'b1010101011;

    // Five ones then five zeros: a single unambiguous edge per word for receiver alignment.
    localparam logic [TMDS_TOKEN_W-1:0] TRAIN_TOKEN = 10'b0000011111;

endpackage

// File: rtl/tmds_param_serializer_if.sv
// Token load handshake between the encoder-side CDC FIFO (master) and the serializer (slave).
interface tmds_param_serializer_if #(
    parameter int CHANNELS = 3,
    parameter int TOKEN_W  = 10
);
    logic [CHANNELS*TOKEN_W-1:0] token_in;
    logic                        token_valid;
    logic                        token_ready;

    modport master (output token_in, output token_valid, input token_ready);
    modport slave  (input token_in, input token_valid, output token_ready);
endinterface

// File: rtl/tmds_lane_shifter.sv
// One channel's load/shift register; emits LANES bits per clock LSB-first, output registered.
// Beat 0 of a loaded token appears the cycle after the load edge; never stalls.
module tmds_lane_shifter #(
    parameter int TOKEN_W = 10,
    parameter int LANES   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [TOKEN_W-1:0] token_i,
    output logic [LANES-1:0]   ser_o
);
    logic [TOKEN_W-1:0] shreg_q, shreg_d;
    logic [LANES-1:0]   ser_q, ser_d;

    // Beat 0 goes straight to the output register so tokens follow each other without a bubble.
    always_comb begin
        shreg_d = shreg_q >> LANES;
        ser_d   = shreg_q[LANES-1:0];
        if (load_i) begin
            shreg_d = token_i >> LANES;
            ser_d   = token_i[LANES-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            ser_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            ser_q   <= ser_d;
        end
    end

    assign ser_o = ser_q;
endmodule

// File: rtl/tmds_param_serializer.sv
// TMDS serializer: one token per channel per frame, shifted out LANES bits/clk, idle token on underflow.
// Optional macro TMDS_SER_TRAINING_EN adds train_en, which forces TRAIN_TOKEN on all channels.
module tmds_param_serializer
    import tmds_pkg::*;
#(
    parameter int                  CHANNELS   = 3,
    parameter int                  TOKEN_W    = TMDS_TOKEN_W,
    parameter int                  LANES      = 2,
    parameter logic [TOKEN_W-1:0]  IDLE_TOKEN = TOKEN_W'(CTRL_00)
) (
    input  logic                      clk,
    input  logic                      rst,
    tmds_param_serializer_if.slave    tok,
    input  logic                      underflow_clr,
`ifdef TMDS_SER_TRAINING_EN
    input  logic                      train_en,
`endif
    output logic [CHANNELS*LANES-1:0] ser_out,
    output logic                      frame_start,
    output logic                      underflow
);
    localparam int BEATS = TOKEN_W / LANES;
    localparam int PH_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(BEATS - 1);

    generate
        if (TOKEN_W % LANES != 0) begin : g_bad_lanes
            $error("tmds_param_serializer: TOKEN_W must be a multiple of LANES");
        end
    endgenerate

    logic [PH_W-1:0] phase_q, phase_d;
    logic            frame_q;
    logic            underflow_q, underflow_d;
    logic            slot, load, training;

    assign slot            = (phase_q == LAST_PH);
    assign load            = slot && !rst;
    assign tok.token_ready = load;

`ifdef TMDS_SER_TRAINING_EN
    assign training = train_en;
`else
    assign training = 1'b0;
`endif

    always_comb begin
        phase_d = slot ? '0 : phase_q + 1'b1;
    end

    // A missed slot in the same cycle as a clear must still leave the flag set.
    always_comb begin
        underflow_d = underflow_q;
        if (underflow_clr)
            underflow_d = 1'b0;
        if (load && !tok.token_valid && !training)
            underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= '0;
            frame_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            frame_q     <= load;
            underflow_q <= underflow_d;
        end
    end

    assign frame_start = frame_q;
    assign underflow   = underflow_q;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [TOKEN_W-1:0] ld_tok;

            always_comb begin
                ld_tok = IDLE_TOKEN;
                if (training)
                    ld_tok = TOKEN_W'(TRAIN_TOKEN);
                else if (tok.token_valid)
                    ld_tok = tok.token_in[c*TOKEN_W +: TOKEN_W];
            end

            tmds_lane_shifter #(
                .TOKEN_W (TOKEN_W),
                .LANES   (LANES)
            ) u_shifter (
                .clk     (clk),
                .rst     (rst),
                .load_i  (load),
                .token_i (ld_tok),
                .ser_o   (ser_out[c*LANES +: LANES])
            );
        end
    endgenerate
endmodule

// File: tb/tb_tmds_param_serializer.sv
// Directed bench: DDR 3-channel instance (A) and SDR 4-channel instance (B), hand-computed beats.
module tb_tmds_param_serializer;
    import tmds_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, clr_a, clr_b;
    logic [5:0] ser_a;
    logic [3:0] ser_b;
    logic       fs_a, fs_b, uf_a, uf_b;
`ifdef TMDS_SER_TRAINING_EN
    logic       train_a, train_b;
`endif

    tmds_param_serializer_if #(.CHANNELS(3), .TOKEN_W(10)) if_a ();
    tmds_param_serializer_if #(.CHANNELS(4), .TOKEN_W(10)) if_b ();

    tmds_param_serializer #(.CHANNELS(3), .TOKEN_W(10), .LANES(2)) dut_a (
        .clk           (clk),
        .rst           (rst_a),
        .tok           (if_a),
        .underflow_clr (clr_a),
`ifdef TMDS_SER_TRAINING_EN
        .train_en      (train_a),
`endif
        .ser_out       (ser_a),
        .frame_start   (fs_a),
        .underflow     (uf_a)
    );

    tmds_param_serializer #(.CHANNELS(4), .TOKEN_W(10), .LANES(1)) dut_b (
        .clk           (clk),
        .rst           (rst_b),
        .tok           (if_b),
        .underflow_clr (clr_b),
`ifdef TMDS_SER_TRAINING_EN
        .train_en      (train_b),
`endif
        .ser_out       (ser_b),
        .frame_start   (fs_b),
        .underflow     (uf_b)
    );

    int vectors = 0;
    int miscompares = 0;

    // {ch2,ch1,ch0} lane pairs per beat for tokens 3E0/155/2AA, and for CTRL_00 on every channel.
    localparam logic [5:0] NORM  [5] = '{6'b000110, 6'b000110, 6'b100110, 6'b110110, 6'b110110};
    localparam logic [5:0] IDLE3 [5] = '{6'b000000, 6'b010101, 6'b010101, 6'b010101, 6'b111111};
    localparam logic [29:0] TOK_A = {10'h3E0, 10'h155, 10'h2AA};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [5:0] s, input logic f,
                           input logic r, input logic u);
        chk({tag, ".ser"}, 32'(ser_a), 32'(s));
        chk({tag, ".fs"},  32'(fs_a), 32'(f));
        chk({tag, ".rdy"}, 32'(if_a.token_ready), 32'(r));
        chk({tag, ".uf"},  32'(uf_a), 32'(u));
    endtask

    task automatic check_b(input string tag, input logic [3:0] s, input logic f,
                           input logic r, input logic u);
        chk({tag, ".ser"}, 32'(ser_b), 32'(s));
        chk({tag, ".fs"},  32'(fs_b), 32'(f));
        chk({tag, ".rdy"}, 32'(if_b.token_ready), 32'(r));
        chk({tag, ".uf"},  32'(uf_b), 32'(u));
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
        if_a.token_valid = 1'b0; if_a.token_in = '0;
        if_b.token_valid = 1'b0; if_b.token_in = '0;
`ifdef TMDS_SER_TRAINING_EN
        train_a = 1'b0; train_b = 1'b0;
`endif
        tick;
        tick;
        check_a("A_reset", 6'd0, 1'b0, 1'b0, 1'b0);

        // Release with tokens already valid: first slot is cycle 4, beat 0 in cycle 5.
        if_a.token_valid = 1'b1;
        if_a.token_in    = TOK_A;
        rst_a            = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_a($sformatf("A_pre%0d", c), 6'd0, 1'b0, c == 4, 1'b0);
            tick;
        end
        for (int c = 5; c < 20; c++) begin
            check_a($sformatf("A_run%0d", c), NORM[c % 5], (c % 5) == 0, (c % 5) == 4, 1'b0);
            tick;
        end

        // Miss the slot at cycle 24; junk on token_in is irrelevant with valid low.
        if_a.token_valid = 1'b0;
        if_a.token_in    = 30'h3FFF_FFFF;
        for (int c = 20; c < 25; c++) begin
            check_a($sformatf("A_drain%0d", c), NORM[c % 5], (c % 5) == 0, (c % 5) == 4, 1'b0);
            tick;
        end
        for (int c = 25; c < 30; c++) begin
            clr_a = (c == 29);
            check_a($sformatf("A_idle%0d", c), IDLE3[c % 5], (c % 5) == 0, (c % 5) == 4, 1'b1);
            tick;
        end
        clr_a            = 1'b0;
        if_a.token_valid = 1'b1;
        if_a.token_in    = TOK_A;
        for (int c = 30; c < 35; c++) begin
            clr_a = (c == 31);
            check_a($sformatf("A_idle2_%0d", c), IDLE3[c % 5], (c % 5) == 0, (c % 5) == 4, c <= 31);
            tick;
        end
        clr_a = 1'b0;

        // Garbage presented away from the slot must not reach the line.
        for (int c = 35; c < 42; c++) begin
            if (c == 35) if_a.token_in = 30'd0;
            if (c == 37) if_a.token_in = TOK_A;
            check_a($sformatf("A_ign%0d", c), NORM[c % 5], (c % 5) == 0, (c % 5) == 4, 1'b0);
            tick;
        end

        // Reset on beat 2, held across several would-be slots with no valid token.
        check_a("A_beat2", NORM[2], 1'b0, 1'b0, 1'b0);
        rst_a            = 1'b1;
        if_a.token_valid = 1'b0;
        tick;
        for (int k = 0; k < 6; k++) begin
            check_a($sformatf("A_inrst%0d", k), 6'd0, 1'b0, 1'b0, 1'b0);
            tick;
        end
        rst_a            = 1'b0;
        if_a.token_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check_a($sformatf("A_rpre%0d", c), 6'd0, 1'b0, c == 4, 1'b0);
            tick;
        end
        for (int c = 5; c < 15; c++) begin
            check_a($sformatf("A_rrun%0d", c), NORM[c % 5], (c % 5) == 0, (c % 5) == 4, 1'b0);
            tick;
        end

        // SDR, 4 channels, token 001: a single 1 then nine 0s, ready every 10 cycles.
        check_b("B_reset", 4'h0, 1'b0, 1'b0, 1'b0);
        if_b.token_valid = 1'b1;
        if_b.token_in    = {4{10'h001}};
        rst_b            = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check_b($sformatf("B_pre%0d", c), 4'h0, 1'b0, c == 9, 1'b0);
            tick;
        end
        for (int c = 10; c < 30; c++) begin
            check_b($sformatf("B_run%0d", c), ((c % 10) == 0) ? 4'hF : 4'h0,
                    (c % 10) == 0, (c % 10) == 9, 1'b0);
            tick;
        end

`ifdef TMDS_SER_TRAINING_EN
        train_b          = 1'b1;
        if_b.token_valid = 1'b0;
        for (int c = 30; c < 50; c++) begin
            logic [3:0] es;
            if (c < 40) es = ((c % 10) == 0) ? 4'hF : 4'h0;
            else        es = ((c % 10) < 5)  ? 4'hF : 4'h0;
            check_b($sformatf("B_train%0d", c), es, (c % 10) == 0, (c % 10) == 9, 1'b0);
            tick;
        end
        train_b = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
